// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: display prefetch of 4x4 pixel blocks has priority
// over a req/ack writer that owns the RAM port in every other clock.
module vram_arbiter #(
  parameter int COLS = 160,
  parameter int ROWS = 120,
  parameter int AW   = 15
) (
  input  logic          clk_50M,
  input  logic          rst,
  input  logic          p_tick,
  input  logic          video_on,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_data,
  output logic          wr_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [2:0]    ram_wdata,
  input  logic [2:0]    ram_rdata,
  output logic [2:0]    rgb,
  output logic          fetch_miss,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } state_t;

  localparam logic [8:0]    COLS_W  = 9'(COLS);
  localparam logic [AW-1:0] FB_SIZE = AW'(COLS * ROWS);

  state_t        state, state_nxt;
  logic          fetch_pend;
  logic          in_flight;
  logic [AW-1:0] fetch_addr;
  logic [2:0]    nxt_reg;
  logic [2:0]    pix_reg;
  logic [AW-1:0] addr_q;
  logic [2:0]    wdata_q;

  // Block coordinates and prefetch address generation
  logic [7:0]    col;
  logic [7:0]    row;
  logic [9:0]    next_y;
  logic [7:0]    next_row;
  logic [AW-1:0] row_ext;
  logic [AW-1:0] next_row_ext;
  logic [AW-1:0] row_base;
  logic [AW-1:0] next_row_base;
  logic          col_fetch;
  logic          line_fetch;
  logic          fetch_set;
  logic [AW-1:0] fetch_addr_nxt;

  assign col          = pixel_x[9:2];
  assign row          = pixel_y[9:2];
  assign next_y       = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
  assign next_row     = next_y[9:2];
  assign row_ext      = {{(AW-8){1'b0}}, row};
  assign next_row_ext = {{(AW-8){1'b0}}, next_row};
  // 160 = 128 + 32, so the row base is two shifted copies added together
  assign row_base      = (row_ext << 7) + (row_ext << 5);
  assign next_row_base = (next_row_ext << 7) + (next_row_ext << 5);

  assign col_fetch  = p_tick && (pixel_x[1:0] == 2'b00) && (({1'b0, col} + 9'd1) < COLS_W);
  assign line_fetch = p_tick && (pixel_x == 10'd796) &&
                      !((next_y >= 10'd480) && (next_y <= 10'd524));
  assign fetch_set  = col_fetch || line_fetch;
  assign fetch_addr_nxt = line_fetch ? next_row_base
                                     : row_base + {{(AW-8){1'b0}}, col} + AW'(1);

  // Writer handshake: wr_addr/wr_data are held while wr_req is high; the write is
  // taken in the single clock where wr_ack is high, and wr_req is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    wr_ack    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    case (state)
      IDLE: begin
        if (fetch_pend || fetch_set) state_nxt = FETCH;
        else if (wr_req)             state_nxt = WRITE;
      end
      FETCH: begin
        ram_addr  = fetch_addr;
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = IDLE;
      WRITE: begin
        ram_addr  = wr_addr;
        ram_wdata = wr_data;
        wr_ack    = 1'b1;
        ram_we    = (wr_addr < FB_SIZE);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
    end
  end

  // in_flight stays high from the request until the read data is captured
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      fetch_pend <= 1'b0;
      in_flight  <= 1'b0;
      fetch_addr <= '0;
    end else if (fetch_set) begin
      fetch_pend <= 1'b1;
      in_flight  <= 1'b1;
      fetch_addr <= fetch_addr_nxt;
    end else begin
      if (state == FETCH)   fetch_pend <= 1'b0;
      if (state == CAPTURE) in_flight  <= 1'b0;
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      nxt_reg    <= '0;
      pix_reg    <= '0;
      fetch_miss <= 1'b0;
    end else begin
      if (state == CAPTURE) nxt_reg <= ram_rdata;
      if (p_tick && (pixel_x[1:0] == 2'b11)) begin
        pix_reg <= nxt_reg;
        if (fetch_pend || in_flight) fetch_miss <= 1'b1;
      end
    end
  end

  assign rgb       = video_on ? pix_reg : 3'b000;
  assign state_dbg = state;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: fetch-address table, arbitration sequences,
// display runs against a behavioural synchronous RAM, and reset/underrun corners.
module tb_vram_arbiter;

  localparam int AW = 15;
  localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_CAPTURE = 2'd2, S_WRITE = 2'd3;

  logic          clk_50M = 1'b0;
  logic          rst;
  logic          p_tick;
  logic          video_on;
  logic [9:0]    pixel_x;
  logic [9:0]    pixel_y;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          wr_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [2:0]    ram_wdata;
  logic [2:0]    ram_rdata;
  logic [2:0]    rgb;
  logic          fetch_miss;
  logic [1:0]    state_dbg;

  vram_arbiter #(.COLS(160), .ROWS(120), .AW(AW)) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .rgb        (rgb),
    .fetch_miss (fetch_miss),
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog
  always #10 clk_50M = ~clk_50M;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Behavioural single-port RAM with one-clock read latency and a bulk fill
  logic [2:0] mem [0:32767];
  logic       fill_en = 1'b0;
  int         fill_off = 0;

  always @(posedge clk_50M) begin
    if (fill_en) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 3'((i + fill_off) % 8);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic [17:0] e;
  int n_writes = 0;
  int wait_cnt = 0;
  logic free_run = 1'b0;
  logic wr_auto = 1'b0;
  logic wr_commit = 1'b0;
  logic advanced = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d t=%0t)", name, act, exp, pixel_x, pixel_y, $time);
    end
  endtask

  function automatic int exp_pix(input int x, input int y, input int off);
    if (x < 640 && y < 480) return ((y / 4) * 160 + x / 4 + off) % 8;
    return 0;
  endfunction

  // One clock: record committed writes, follow the writer handshake, advance the sync counters
  task automatic step();
    @(posedge clk_50M);
    #1;
    advanced = 1'b0;
    if (wr_commit) begin
      exp_q.push_back({wr_addr, wr_data});
      n_writes++;
      wr_addr   = wr_addr + 15'd1;
      wr_data   = wr_data + 3'd1;
      wr_commit = 1'b0;
    end
    if (wr_auto) begin
      if (wr_ack) begin
        check("wr_wait_le8", int'(wait_cnt <= 8), 1);
        wr_commit = 1'b1;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end
    if (free_run) begin
      if (p_tick) begin
        if (pixel_x == 10'd799) begin
          pixel_x = 10'd0;
          pixel_y = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
        end else begin
          pixel_x = pixel_x + 10'd1;
        end
        advanced = 1'b1;
      end
      p_tick   = ~p_tick;
      video_on = (pixel_x < 10'd640) && (pixel_y < 10'd480);
    end
    #1;
  endtask

  task automatic fill(input int off);
    fill_off = off;
    fill_en  = 1'b1;
    step();
    fill_en  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [9:0]    px;
    logic [9:0]    py;
    logic          pt;
    logic          exp_fetch;
    logic [AW-1:0] exp_addr;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    // Vectors: one clock at (px,py,p_tick) from IDLE -> FETCH? and its address
    vecs[0]  = '{10'd0,   10'd0,   1'b1, 1'b1, 15'd1};
    vecs[1]  = '{10'd0,   10'd0,   1'b0, 1'b0, 15'd0};
    vecs[2]  = '{10'd4,   10'd0,   1'b1, 1'b1, 15'd2};
    vecs[3]  = '{10'd632, 10'd0,   1'b1, 1'b1, 15'd159};
    vecs[4]  = '{10'd636, 10'd0,   1'b1, 1'b0, 15'd0};
    vecs[5]  = '{10'd2,   10'd0,   1'b1, 1'b0, 15'd0};
    vecs[6]  = '{10'd797, 10'd10,  1'b1, 1'b0, 15'd0};
    vecs[7]  = '{10'd796, 10'd3,   1'b1, 1'b1, 15'd160};
    vecs[8]  = '{10'd796, 10'd524, 1'b1, 1'b1, 15'd0};
    vecs[9]  = '{10'd796, 10'd479, 1'b1, 1'b0, 15'd0};
    vecs[10] = '{10'd796, 10'd523, 1'b1, 1'b0, 15'd0};
    vecs[11] = '{10'd0,   10'd479, 1'b1, 1'b1, 15'd19041};
    vecs[12] = '{10'd8,   10'd100, 1'b1, 1'b1, 15'd4003};
    vecs[13] = '{10'd796, 10'd478, 1'b1, 1'b1, 15'd19040};
    vecs[14] = '{10'd796, 10'd0,   1'b1, 1'b1, 15'd0};
    vecs[15] = '{10'd640, 10'd8,   1'b1, 1'b0, 15'd0};
    vecs[16] = '{10'd628, 10'd476, 1'b1, 1'b1, 15'd19198};

    rst = 1'b1; p_tick = 1'b0; video_on = 1'b1; pixel_x = '0; pixel_y = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    #5;
    check("rst_wr_ack", wr_ack, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_rgb", rgb, 0);
    check("rst_fetch_miss", fetch_miss, 0);
    check("rst_state", state_dbg, S_IDLE);
    fill(0);
    video_on = 1'b0;
    do_reset();

    // Fetch-address table
    for (int i = 0; i < NV; i++) begin
      pixel_x = vecs[i].px;
      pixel_y = vecs[i].py;
      p_tick  = vecs[i].pt;
      step();
      p_tick = 1'b0;
      check("tbl_fetch", int'(state_dbg == S_FETCH), vecs[i].exp_fetch);
      if (vecs[i].exp_fetch) check("tbl_addr", ram_addr, vecs[i].exp_addr);
      check("tbl_we", ram_we, 0);
      step();
      step();
    end

    // Write requested on the same clock a fetch is raised: fetch first, ack three clocks later
    pixel_x = 10'd4; pixel_y = 10'd0; p_tick = 1'b1;
    wr_req = 1'b1; wr_addr = 15'd300; wr_data = 3'd6;
    step();
    p_tick = 1'b0;
    check("coll_state0", state_dbg, S_FETCH);
    check("coll_ack0", wr_ack, 0);
    step();
    check("coll_state1", state_dbg, S_CAPTURE);
    check("coll_ack1", wr_ack, 0);
    step();
    check("coll_ack2", wr_ack, 0);
    step();
    check("coll_ack3", wr_ack, 1);
    check("coll_we3", ram_we, 1);
    check("coll_addr3", ram_addr, 300);
    check("coll_wdata3", ram_wdata, 6);
    wr_req = 1'b0;
    step();
    check("coll_ack4", wr_ack, 0);
    check("coll_mem300", mem[300], 6);

    // Out-of-range write is acked but discarded; last in-range address is written
    wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 3'd7;
    step();
    wr_req = 1'b0;
    check("oor_ack", wr_ack, 1);
    check("oor_we", ram_we, 0);
    step();
    check("oor_mem", mem[19200], 0);
    wr_req = 1'b1; wr_addr = 15'd19199; wr_data = 3'd2;
    step();
    wr_req = 1'b0;
    check("last_ack", wr_ack, 1);
    check("last_we", ram_we, 1);
    step();
    check("last_mem", mem[19199], 2);

    // Display from frame origin; writer hammers the port during lines 4..7
    fill(0);
    pixel_x = '0; pixel_y = '0; p_tick = 1'b1; video_on = 1'b1;
    do_reset();
    free_run = 1'b1;
    for (int n = 0; n < 14000 && pixel_y != 10'd8; n++) begin
      if (pixel_y == 10'd4 && !wr_auto && n_writes == 0) begin
        wr_auto = 1'b1; wr_req = 1'b1; wr_addr = 15'd8000; wr_data = 3'd1; wait_cnt = 0;
      end
      step();
      check("runA_we_fetch", int'(ram_we && state_dbg == S_FETCH), 0);
      if (advanced) check("runA_rgb", rgb, exp_pix(pixel_x, pixel_y, 0));
    end
    check("runA_end_line", pixel_y, 8);
    wr_auto = 1'b0; wr_req = 1'b0;
    step();
    step();
    check("runA_miss", fetch_miss, 0);
    check("runA_enough_writes", int'(n_writes >= 1000), 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("runA_mem", mem[e[17:3]], e[2:0]);
    end

    // Frame wrap: the fetch at the end of line 524 supplies block 0 of line 0
    free_run = 1'b0;
    fill(5);
    pixel_x = 10'd780; pixel_y = 10'd523; p_tick = 1'b1; video_on = 1'b0;
    free_run = 1'b1;
    for (int n = 0; n < 6000 && pixel_y != 10'd2; n++) begin
      step();
      if (advanced) check("wrap_rgb", rgb, exp_pix(pixel_x, pixel_y, 5));
    end
    check("wrap_end_line", pixel_y, 2);
    free_run = 1'b0;
    check("wrap_miss", fetch_miss, 0);

    // Reset landing inside a WRITE aborts it
    p_tick = 1'b0; video_on = 1'b1;
    wr_req = 1'b1; wr_addr = 15'd500; wr_data = 3'd3;
    step();
    check("rstw_in_write", state_dbg, S_WRITE);
    #2 rst = 1'b1;
    #1;
    check("rstw_ack", wr_ack, 0);
    check("rstw_we", ram_we, 0);
    check("rstw_addr", ram_addr, 0);
    check("rstw_wdata", ram_wdata, 0);
    check("rstw_rgb", rgb, 0);
    check("rstw_miss", fetch_miss, 0);
    wr_req = 1'b0;
    step();
    rst = 1'b0;
    check("rstw_mem500", mem[500], 1);
    pixel_x = 10'd8; pixel_y = 10'd2; p_tick = 1'b1;
    step();
    p_tick = 1'b0;
    check("rstw_resume_state", state_dbg, S_FETCH);
    check("rstw_resume_addr", ram_addr, 3);
    step();
    step();

    // Underrun: the block boundary arrives while the fetch is still in flight
    pixel_x = 10'd12; pixel_y = 10'd2; p_tick = 1'b1;
    step();
    check("miss_before", fetch_miss, 0);
    pixel_x = 10'd15;
    step();
    p_tick = 1'b0;
    check("miss_set", fetch_miss, 1);
    step();
    step();
    step();
    check("miss_sticky", fetch_miss, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameters: COLS, 160, framebuffer columns; ROWS, 120, framebuffer rows; AW, 15, RAM address width.
REQ-002 SHALL have ports:
  clk_50M  in  1  system clock; all logic on rising edge.
  rst  in  1  asynchronous, active-high reset.
  p_tick  in  1  pixel enable from sync generator, high every 2nd clock.
  video_on  in  1  active-area flag from sync generator.
  pixel_x  in  10  current column, 0..799.
  pixel_y  in  10  current line, 0..524.
  wr_req  in  1  writer request; wr_addr/wr_data held stable until wr_ack.
  wr_addr  in  AW  writer framebuffer address.
  wr_data  in  3  writer RGB pixel.
  wr_ack  out  1  one-clock pulse: write accepted.
  ram_addr  out  AW  single-port RAM address.
  ram_we  out  1  RAM write enable.
  ram_wdata  out  3  RAM write data.
  ram_rdata  in  3  RAM read data, valid 1 clock after address (synchronous read).
  rgb  out  3  pixel colour to DAC.
  fetch_miss  out  1  sticky display-underrun flag.

Function
REQ-003 SHALL share one RAM port between display fetch (priority) and writer; each framebuffer pixel covers a 4x4 screen block.
REQ-004 SHALL use block coordinates col = pixel_x[9:2], row = pixel_y[9:2]; address = row*160 + col (shift-add, AW bits).
REQ-005 SHALL raise fetch_pend on a clock with p_tick=1 and pixel_x[1:0]=0 when col+1 < 160, latching address (row, col+1).
REQ-006 SHALL, at pixel_x=796 with p_tick=1, latch address (next_row, 0), next_y = 0 if pixel_y=524 else pixel_y+1; skipped when 480 <= next_y <= 524.
REQ-007 SHALL implement FSM IDLE, FETCH, CAPTURE, WRITE.
REQ-008 IDLE: fetch_pend -> FETCH; else wr_req -> WRITE; else stay.
REQ-009 FETCH: ram_addr = latched fetch address, ram_we=0, clear fetch_pend; -> CAPTURE.
REQ-010 CAPTURE: nxt_reg <= ram_rdata; -> IDLE.
REQ-011 WRITE: ram_addr = wr_addr, ram_wdata = wr_data, wr_ack=1 for this clock; ram_we=1 only if wr_addr < 19200; -> IDLE unconditionally.
REQ-012 Out-of-range wr_addr (>= 19200) SHALL be acked and discarded, RAM unmodified.
REQ-013 Writer throughput SHALL be at most one write per 2 clocks; wr_req sampled only in IDLE.
REQ-014 Fetch and write arriving in IDLE on same clock: fetch wins; write waits.
REQ-015 Fetch set during WRITE SHALL complete (nxt_reg loaded) within 4 clocks of set edge.
REQ-016 On p_tick=1 and pixel_x[1:0]=3: pix_reg <= nxt_reg; if fetch_pend still set or CAPTURE not yet done since last set, fetch_miss <= 1 (sticky).
REQ-017 rgb SHALL equal pix_reg when video_on=1, else 3'b000 (combinational from registers).
REQ-018 Outside fetch windows writer SHALL have full RAM access, including all blanking.
REQ-019 In IDLE/no-op states ram_we=0, ram_addr = last driven value.

Reset
REQ-020 rst=1 SHALL asynchronously force: state IDLE, fetch_pend=0, fetch address=0, nxt_reg=0, pix_reg=0, fetch_miss=0, wr_ack=0, ram_we=0, ram_addr=0, ram_wdata=0; rgb=0.
REQ-021 Reset mid-WRITE SHALL abort without ack; writer must re-request after release.
REQ-022 After release, first fetch occurs at next qualifying pixel_x; first displayed block may be 0.

Verification
REQ-023 Fill RAM with addr mod 8, run full frame from pixel_x=0,pixel_y=0 -> rgb at (x,y) in active area equals ((y/4)*160 + x/4) mod 8; fetch_miss=0.
REQ-024 wr_req held continuously during active video -> each write acked, no fetch_miss, ram_we never coincides with FETCH.
REQ-025 wr_req asserted in IDLE same clock fetch_pend rises -> FETCH first, wr_ack 3 clocks later.
REQ-026 wr_addr=19200, wr_req=1 -> wr_ack pulse, ram_we stays 0, RAM unchanged.
REQ-027 pixel_y=524, pixel_x=796 -> fetch address 0; at pixel_y=479, pixel_x=796 -> no fetch issued.
REQ-028 rst pulsed while in WRITE -> wr_ack not asserted, all outputs 0 within the reset clock, normal fetch resumes at next pixel_x[1:0]=0.
